// File: rtl/clb_cfg_pkg.sv
// Shared constants, CFG field layout and FSM state type for the CLB configuration loader.
package clb_cfg_pkg;

   localparam int unsigned CFG_W    = 37;
   localparam logic [7:0]  PREAMBLE = 8'b1111_0010;
   localparam logic [36:0] CFG_INIT = 37'b10_10_10_00_00_0000000100010110_00_000_111_00_0;

   // Field LSB offsets and widths within CFG (MSB first: mux2sel .. floporlatch)
   localparam int unsigned MUX2SEL_LSB     = 35, MUX2SEL_W     = 2;
   localparam int unsigned MUX3SEL_LSB     = 33, MUX3SEL_W     = 2;
   localparam int unsigned MUX4SEL_LSB     = 31, MUX4SEL_W     = 2;
   localparam int unsigned MUX5SEL_LSB     = 29, MUX5SEL_W     = 2;
   localparam int unsigned MUX6SEL_LSB     = 27, MUX6SEL_W     = 2;
   localparam int unsigned MEM_LSB         = 11, MEM_W         = 16;
   localparam int unsigned COMBOPTION_LSB  = 9,  COMBOPTION_W  = 2;
   localparam int unsigned O2M1_0_LSB      = 8;
   localparam int unsigned O2M2_0_LSB      = 7;
   localparam int unsigned O2M3_0_LSB      = 6;
   localparam int unsigned O2M1_1_LSB      = 5;
   localparam int unsigned O2M2_1_LSB      = 4;
   localparam int unsigned O2M3_1_LSB      = 3;
   localparam int unsigned DQMUX1_LSB      = 2;
   localparam int unsigned DQMUX2_LSB      = 1;
   localparam int unsigned FLOPORLATCH_LSB = 0;

   typedef enum logic [1:0] {
      HUNT = 2'd0,
      LOAD = 2'd1,
      PAR  = 2'd2
   } state_t;

endpackage

// File: rtl/clb_cfg_shreg.sv
// MSB-first shift register with synchronous clear (clear wins over shift).
module clb_cfg_shreg #(
   parameter int unsigned W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         en,
   input  logic         din,
   output logic [W-1:0] q
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst)       q <= '0;
      else if (clr)  q <= '0;
      else if (en)   q <= {q[W-2:0], din};
   end

endmodule

// File: rtl/clb_cfg_loader.sv
// Serial configuration loader: preamble hunt, CFG_W-bit frame shift-in, even-parity check
// and atomic commit of the CLB configuration word.
module clb_cfg_loader #(
   parameter int unsigned      CFG_W    = clb_cfg_pkg::CFG_W,
   parameter logic [7:0]       PREAMBLE = clb_cfg_pkg::PREAMBLE,
   parameter logic [CFG_W-1:0] CFG_INIT = clb_cfg_pkg::CFG_INIT
) (
   input  logic             K,
   input  logic             RST,
   input  logic             PROG,
   input  logic             DIN,
   input  logic             DVALID,
   output logic [CFG_W-1:0] CFG,
   output logic             DONE,
   output logic             ERR,
   output logic             BUSY
);

   import clb_cfg_pkg::*;

   localparam int unsigned CNT_W = $clog2(CFG_W + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CFG_W - 1);

   state_t           state, state_nx;
   logic [7:0]       hist;
   logic [CFG_W-1:0] shadow;
   logic [CNT_W-1:0] cnt;
   logic             par_acc;
   logic             accept, hist_sh, load_sh, match, par_done;
   logic             unused_hist_msb;

   assign accept          = DVALID & ~PROG;
   assign unused_hist_msb = hist[7];

   always_ff @(posedge K or posedge RST) begin
      if (RST) state <= HUNT;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      hist_sh  = 1'b0;
      load_sh  = 1'b0;
      match    = 1'b0;
      par_done = 1'b0;
      unique case (state)
         HUNT: begin
            hist_sh = accept;
            // Compare against the history plus the bit arriving now so the match edge is the last preamble bit
            if (accept && ({hist[6:0], DIN} == PREAMBLE)) begin
               match    = 1'b1;
               state_nx = LOAD;
            end
         end
         LOAD: begin
            load_sh = accept;
            if (accept && (cnt == CNT_LAST)) state_nx = PAR;
         end
         PAR: begin
            if (accept) begin
               par_done = 1'b1;
               state_nx = HUNT;
            end
         end
         default: state_nx = HUNT;
      endcase
      if (PROG) state_nx = HUNT;
   end

   clb_cfg_shreg #(.W(8)) u_hist (
      .clk (K),
      .rst (RST),
      .clr (PROG | par_done),
      .en  (hist_sh),
      .din (DIN),
      .q   (hist)
   );

   clb_cfg_shreg #(.W(CFG_W)) u_shadow (
      .clk (K),
      .rst (RST),
      .clr (PROG | match),
      .en  (load_sh),
      .din (DIN),
      .q   (shadow)
   );

   always_ff @(posedge K or posedge RST) begin
      if (RST) begin
         cnt     <= '0;
         par_acc <= 1'b0;
         CFG     <= CFG_INIT;
         DONE    <= 1'b0;
         ERR     <= 1'b0;
         BUSY    <= 1'b0;
      end else if (PROG) begin
         cnt     <= '0;
         par_acc <= 1'b0;
         CFG     <= CFG_INIT;
         DONE    <= 1'b0;
         ERR     <= 1'b0;
         BUSY    <= 1'b0;
      end else begin
         BUSY <= (state_nx != HUNT);
         if (match) begin
            cnt     <= '0;
            par_acc <= 1'b0;
            DONE    <= 1'b0;
            ERR     <= 1'b0;
         end
         if (load_sh) begin
            par_acc <= par_acc ^ DIN;
            cnt     <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
         end
         // Running XOR equals the reduction of the full shadow by the time the parity bit arrives
         if (par_done) begin
            if (par_acc ^ DIN) begin
               ERR <= 1'b1;
            end else begin
               CFG  <= shadow;
               DONE <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_clb_cfg_loader.sv
// Scoreboard bench for clb_cfg_loader: each frame pushes its expected outcome, and a
// monitor checks CFG/DONE/ERR and the busy length whenever BUSY falls.
module tb_clb_cfg_loader;

   localparam logic [36:0] INIT_C = 37'b10_10_10_00_00_0000000100010110_00_000_111_00_0;
   localparam logic [7:0]  PRE_C  = 8'b1111_0010;

   logic        K, RST, PROG, DIN, DVALID;
   logic [36:0] CFG;
   logic        DONE, ERR, BUSY;

   typedef struct {
      string       name;
      logic [36:0] cfg;
      logic        done;
      logic        err;
      int unsigned len;
   } exp_t;

   exp_t        exp_q[$];
   int unsigned checks = 0;
   int unsigned passes = 0;
   int unsigned busy_cnt = 0;
   logic        prev_busy = 1'b0;

   clb_cfg_loader dut (
      .K      (K),
      .RST    (RST),
      .PROG   (PROG),
      .DIN    (DIN),
      .DVALID (DVALID),
      .CFG    (CFG),
      .DONE   (DONE),
      .ERR    (ERR),
      .BUSY   (BUSY)
   );

   initial K = 1'b0;
   always #5 K = ~K;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic send_bit(input logic b, input bit gap);
      DIN    = b;
      DVALID = 1'b1;
      @(posedge K); #1;
      if (gap) begin
         DVALID = 1'b0;
         DIN    = ~b;
         @(posedge K); #1;
      end
   endtask

   task automatic send_pre(input bit gap);
      logic [7:0] p;
      p = PRE_C;
      for (int i = 7; i >= 0; i--) send_bit(p[i], gap);
   endtask

   task automatic send_frame(input logic [36:0] data, input logic par, input bit gap);
      send_pre(gap);
      for (int i = 36; i >= 0; i--) send_bit(data[i], gap);
      send_bit(par, gap);
      DVALID = 1'b0;
   endtask

   task automatic expect_frame(input string name, input logic [36:0] cfg, input logic done,
                               input logic err, input int unsigned len);
      exp_t e;
      e.name = name; e.cfg = cfg; e.done = done; e.err = err; e.len = len;
      exp_q.push_back(e);
   endtask

   // Monitor: frame outcome is presented on the cycle BUSY drops
   always @(negedge K) begin
      if (!RST) begin
         if (BUSY && !prev_busy) begin
            chk("done_clear_on_preamble", {63'd0, DONE}, 64'd0);
            chk("err_clear_on_preamble", {63'd0, ERR}, 64'd0);
         end
         if (BUSY) busy_cnt++;
         if (!BUSY && prev_busy) begin
            if (exp_q.size() == 0) begin
               checks++;
               $display("FAIL unexpected_frame_end: got BUSY fall expected none");
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               chk({e.name, "_cfg"}, {27'd0, CFG}, {27'd0, e.cfg});
               chk({e.name, "_done"}, {63'd0, DONE}, {63'd0, e.done});
               chk({e.name, "_err"}, {63'd0, ERR}, {63'd0, e.err});
               chk({e.name, "_busy_len"}, 64'(busy_cnt), 64'(e.len));
            end
            busy_cnt = 0;
         end
         prev_busy = BUSY;
      end
   end

   initial begin
      logic [36:0] d;
      RST = 1'b0; PROG = 1'b0; DIN = 1'b0; DVALID = 1'b0;
      #1 RST = 1'b1;
      #1;
      chk("reset_cfg", {27'd0, CFG}, {27'd0, INIT_C});
      chk("reset_done", {63'd0, DONE}, 64'd0);
      chk("reset_err", {63'd0, ERR}, 64'd0);
      chk("reset_busy", {63'd0, BUSY}, 64'd0);
      @(posedge K); #1;
      RST = 1'b0;
      @(posedge K); #1;

      expect_frame("good", 37'h1F_FFFF_FFFF, 1'b1, 1'b0, 38);
      send_frame(37'h1F_FFFF_FFFF, 1'b1, 1'b0);

      // Starts on the edge right after the previous parity edge
      expect_frame("bad_parity", 37'h1F_FFFF_FFFF, 1'b0, 1'b1, 38);
      send_frame(37'h1F_FFFF_FFFF, 1'b0, 1'b0);

      // 17 ones in data -> parity 1
      expect_frame("gapped", 37'h12_3456_789A, 1'b1, 1'b0, 76);
      send_frame(37'h12_3456_789A, 1'b1, 1'b1);
      repeat (3) @(posedge K);
      #1;

      // 1111 + preamble -> 1111_1111_0010; data has 19 ones -> parity 1
      for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b0);
      expect_frame("noise", 37'h15_5555_5555, 1'b1, 1'b0, 38);
      send_frame(37'h15_5555_5555, 1'b1, 1'b0);

      expect_frame("prog_abort", INIT_C, 1'b0, 1'b0, 21);
      send_pre(1'b0);
      d = 37'h0A_AAAA_AAAA;
      for (int i = 36; i >= 17; i--) send_bit(d[i], 1'b0);
      DIN = 1'b1; DVALID = 1'b1; PROG = 1'b1;
      @(posedge K); #1;
      PROG = 1'b0; DVALID = 1'b0;
      @(posedge K); #1;

      // 20 ones -> parity 0
      expect_frame("after_prog", 37'h0F_0F0F_0F0F, 1'b1, 1'b0, 38);
      send_frame(37'h0F_0F0F_0F0F, 1'b0, 1'b0);

      for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(posedge K);
      if (exp_q.size() != 0) begin
         checks++;
         $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
      end
      repeat (4) @(posedge K);
      #1;
      chk("idle_cfg_hold", {27'd0, CFG}, {27'd0, 37'h0F_0F0F_0F0F});
      chk("idle_busy", {63'd0, BUSY}, 64'd0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
